seq_shifter: RTL and testbench

- Parametrised multi-cycle shift unit; successor to the 1-bit left shifter.
- Supports logical left, logical right and arithmetic right shifts by a variable amount.
- Shifts up to StepBits positions per cycle, trading latency for area.
- Sits beside the ALU as a shared iterative shift resource, with a start/done handshake toward the datapath controller.

---
 rtl/seq_shifter.sv | 77 +++++++
 tb/tb_seq_shifter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter: iterative SLL/SRL/SRA shifter, up to StepBits positions per cycle.
// Ports: clk, rst_n (sync, active-low), start/mode/in_data/shamt (request, sampled in IDLE),
//        busy (SHIFT or DONE), done (one-cycle result pulse), out_data (result register).
// Macro SEQ_SHIFTER_ROTATE_EN: mode 11 rotates left; otherwise mode 11 behaves as SLL.
module seq_shifter #(
  parameter int Width    = 32,
  parameter int ShamtW   = $clog2(Width),
  parameter int StepBits = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [Width-1:0]  in_data,
  input  logic [ShamtW-1:0] shamt,
  output logic              busy,
  output logic              done,
  output logic [Width-1:0]  out_data
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e state_q, state_d;
  logic [Width-1:0] data_q, data_d, out_q, out_d, shifted;
  logic [ShamtW-1:0] rem_q, rem_d, step;
  logic [1:0] mode_q, mode_d;
  // The StepBits branch is only taken when rem_q exceeds it, so the cast never truncates.
  assign step = (32'(rem_q) > StepBits) ? ShamtW'(StepBits) : rem_q;
  always_comb begin
    shifted = data_q << step;
    if (mode_q == 2'b01) shifted = data_q >> step;
    if (mode_q == 2'b10) shifted = $signed(data_q) >>> step;
`ifdef SEQ_SHIFTER_ROTATE_EN
    // step is never zero while shifting, so Width - step stays below Width.
    if (mode_q == 2'b11) shifted = (data_q << step) | (data_q >> (Width - 32'(step)));
`endif
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    out_d   = out_q;
    case (state_q)
      IDLE: if (start) begin
        data_d  = in_data;
        mode_d  = mode;
        rem_d   = shamt;
        state_d = SHIFT;
      end
      SHIFT: if (rem_q != '0) begin
        data_d = shifted;
        rem_d  = rem_q - step;
      end else begin
        out_d   = data_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign out_data = out_q;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench driving StepBits=1 and StepBits=4 shifters in lockstep.
module tb_seq_shifter;
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam bit Rot = 1'b1;
`else
  localparam bit Rot = 1'b0;
`endif
  typedef struct {logic [31:0] d; int st; int fin;} ent_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] mode = 0;
  logic [31:0] in_data = 0;
  logic [4:0] shamt = 0;
  logic busy_w [2];
  logic done_w [2];
  logic [31:0] out_w [2];
  logic [31:0] last [2];
  ent_t sb [2][$];
  int steps [2] = '{1, 4};
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  seq_shifter #(.Width(32), .StepBits(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_data(in_data), .shamt(shamt),
    .busy(busy_w[0]), .done(done_w[0]), .out_data(out_w[0])
  );
  seq_shifter #(.Width(32), .StepBits(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .in_data(in_data), .shamt(shamt),
    .busy(busy_w[1]), .done(done_w[1]), .out_data(out_w[1])
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d, input int sh);
    for (int i = 0; i < sh; i++)
      d = m == 2'b01 ? {1'b0, d[31:1]} :
          m == 2'b10 ? {d[31], d[31:1]} :
          (Rot && m == 2'b11) ? {d[30:0], d[31]} : {d[30:0], 1'b0};
    return d;
  endfunction
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) begin
      if (sb[u].size() != 0 && cyc == sb[u][0].fin) begin
        chk($sformatf("u%0d_done", u), done_w[u], 1);
        chk($sformatf("u%0d_busy_at_done", u), busy_w[u], 1);
        chk($sformatf("u%0d_result", u), out_w[u], sb[u][0].d);
        last[u] = sb[u][0].d;
        void'(sb[u].pop_front());
      end else begin
        chk($sformatf("u%0d_no_done", u), done_w[u], 0);
        chk($sformatf("u%0d_hold", u), out_w[u], last[u]);
        if (sb[u].size() != 0 && cyc >= sb[u][0].st) chk($sformatf("u%0d_busy", u), busy_w[u], 1);
      end
    end
  end
  task automatic run(input logic [1:0] m, input logic [31:0] d, input logic [4:0] sh,
                     input bit glitch, input bit rst_mid);
    int n;
    @(negedge clk);
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_before_start", {31'b0, busy_w[0] | busy_w[1]}, 0);
    start = 1; mode = m; in_data = d; shamt = sh;
    for (int u = 0; u < 2; u++)
      sb[u].push_back('{model(m, d, int'(sh)), cyc + 1, cyc + 2 + (int'(sh) + steps[u] - 1) / steps[u]});
    @(negedge clk);
    start = 0; mode = 2'($urandom); in_data = $urandom; shamt = 5'($urandom);
    if (glitch) begin
      @(negedge clk);
      start = 1; shamt = 1; in_data = 32'hFFFF_FFFF;
      @(negedge clk);
      start = 0;
    end
    if (rst_mid) begin
      @(negedge clk);
      rst_n = 0;
      for (int u = 0; u < 2; u++) begin
        sb[u].delete();
        last[u] = 0;
      end
      @(negedge clk);
      rst_n = 1;
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d_abort_busy", u), busy_w[u], 0);
        chk($sformatf("u%0d_abort_out", u), out_w[u], 0);
      end
    end
    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_u0", sb[0].size(), 0);
    chk("drain_u1", sb[1].size(), 0);
  endtask
  initial begin
    last[0] = 0;
    last[1] = 0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_busy", u), busy_w[u], 0);
      chk($sformatf("u%0d_rst_done", u), done_w[u], 0);
      chk($sformatf("u%0d_rst_out", u), out_w[u], 0);
    end
    rst_n = 1;
    run(2'b00, 32'h0000_0001, 5'd31, 0, 0);
    run(2'b10, 32'h8000_0000, 5'd4, 0, 0);
    run(2'b01, 32'h8000_0000, 5'd4, 0, 0);
    run(2'b00, 32'hDEAD_BEEF, 5'd0, 0, 0);
    run(2'b00, 32'h0000_0001, 5'd8, 1, 0);
    run(2'b00, 32'h0000_0001, 5'd20, 0, 1);
    run(2'b01, 32'h0000_00F0, 5'd4, 0, 0);
    run(2'b11, 32'h8000_0001, 5'd1, 0, 0);
    run(2'b10, 32'h1234_5678, 5'd31, 0, 0);
    for (int i = 0; i < 10; i++)
      run(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 0, 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
